// File: rtl/pq_cmd_issuer.sv
`timescale 1ns/1ps
// pq_cmd_issuer: command FIFO plus IDLE/ISSUE/SETTLE sequencer feeding the register-tree
// priority queue. Define PQ_ISSUER_STATS_EN to add the st_push/st_pop/st_err counters.
module pq_cmd_issuer #(
   parameter int DATA_WIDTH    = 16,
   parameter int QUEUE_SIZE    = 8,
   parameter int CMD_DEPTH     = 4,
   parameter int SETTLE_CYCLES = 6
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [1:0]            s_op,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  q_wrt,
   output logic                  q_read,
   output logic [DATA_WIDTH-1:0] q_data,
   input  logic                  q_full,
   input  logic                  q_empty,
   input  logic [DATA_WIDTH-1:0] q_top,
   output logic                  r_valid,
   input  logic                  r_ready,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  r_err
`ifdef PQ_ISSUER_STATS_EN
   ,
   output logic [31:0]           st_push,
   output logic [31:0]           st_pop,
   output logic [31:0]           st_err
`endif
);

   localparam int AW = $clog2(CMD_DEPTH);
   localparam int CW = $clog2(SETTLE_CYCLES);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_REPL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_SETTLE
   } state_e;

   if ((CMD_DEPTH < 2) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("CMD_DEPTH must be a power of 2 and at least 2");
   end
   if (SETTLE_CYCLES < 2) begin : g_bad_settle
      $error("SETTLE_CYCLES must be at least 2");
   end
   if (QUEUE_SIZE < 1) begin : g_bad_qsize
      $error("QUEUE_SIZE must be at least 1");
   end

   op_e                   fifo_op   [CMD_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data [CMD_DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  fifo_wr;
   op_e                   head_op;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  key_ok;

   state_e                state;
   state_e                state_nx;
   logic                  take;
   logic                  wrt_nx;
   logic                  read_nx;
   logic                  err_nx;
   logic                  top_nx;
   logic                  pend_err;
   logic                  pend_top;
   logic [CW-1:0]         settle_cnt;

   // Wrap bit distinguishes full from empty when the index bits match.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign s_ready    = !fifo_full;
   assign fifo_wr    = s_valid && s_ready && (op_e'(s_op) != OP_NOP);
   assign head_op    = fifo_op[rd_ptr[AW-1:0]];
   assign head_data  = fifo_data[rd_ptr[AW-1:0]];
   assign key_ok     = (head_data != '0);

   always_ff @(posedge CLK) begin
      if (fifo_wr) begin
         fifo_op[wr_ptr[AW-1:0]]   <= op_e'(s_op);
         fifo_data[wr_ptr[AW-1:0]] <= s_data;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (take)    rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      take     = 1'b0;
      wrt_nx   = 1'b0;
      read_nx  = 1'b0;
      err_nx   = 1'b0;
      top_nx   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!fifo_empty && !r_valid) begin
               take     = 1'b1;
               state_nx = S_ISSUE;
               unique case (head_op)
                  OP_PUSH: begin
                     if (!q_full && key_ok) wrt_nx = 1'b1;
                     else                   err_nx = 1'b1;
                  end
                  OP_POP: begin
                     if (!q_empty) begin
                        read_nx = 1'b1;
                        top_nx  = 1'b1;
                     end else begin
                        err_nx  = 1'b1;
                     end
                  end
                  OP_REPL: begin
                     if (!key_ok) begin
                        err_nx  = 1'b1;
                     end else if (q_empty) begin
                        // Nothing to replace: insert the key anyway but flag the response.
                        wrt_nx  = 1'b1;
                        err_nx  = 1'b1;
                     end else begin
                        wrt_nx  = 1'b1;
                        read_nx = 1'b1;
                        top_nx  = 1'b1;
                     end
                  end
                  default: err_nx = 1'b1;
               endcase
            end
         end
         S_ISSUE:  state_nx = S_SETTLE;
         S_SETTLE: if (settle_cnt == SETTLE_LAST) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         q_wrt      <= 1'b0;
         q_read     <= 1'b0;
         q_data     <= '0;
         pend_err   <= 1'b0;
         pend_top   <= 1'b0;
         settle_cnt <= '0;
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_err      <= 1'b0;
      end else begin
         q_wrt  <= take && wrt_nx;
         q_read <= take && read_nx;
         q_data <= (take && wrt_nx) ? head_data : '0;
         if (take) begin
            pend_err <= err_nx;
            pend_top <= top_nx;
         end
         settle_cnt <= (state == S_SETTLE) ? settle_cnt + CW'(1) : '0;
         // q_top still shows the pre-op top during ISSUE; the strobe lands at its end.
         if (state == S_ISSUE) begin
            r_valid <= 1'b1;
            r_err   <= pend_err;
            r_data  <= pend_top ? q_top : '0;
         end else if (r_valid && r_ready) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
         end
      end
   end

`ifdef PQ_ISSUER_STATS_EN
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         st_push <= '0;
         st_pop  <= '0;
         st_err  <= '0;
      end else if (state == S_ISSUE) begin
         if (q_wrt  && (st_push != '1)) st_push <= st_push + 32'd1;
         if (q_read && (st_pop  != '1)) st_pop  <= st_pop  + 32'd1;
         if (pend_err && (st_err != '1)) st_err <= st_err  + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pq_cmd_issuer.sv
`timescale 1ns/1ps
// Randomized self-checking bench for pq_cmd_issuer: a behavioural priority queue answers the
// strobes and a command-level reference predicts every response.
module tb_pq_cmd_issuer;
   localparam int DW = 16;
   localparam int QS = 8;
   localparam int DEPTH = 4;
   localparam int SC = 6;
   localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, REPL = 2'b11;

   logic          CLK = 1'b0;
   logic          RSTn = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [1:0]    s_op = 2'b00;
   logic [DW-1:0] s_data = '0;
   logic          q_wrt, q_read;
   logic [DW-1:0] q_data;
   logic          q_full = 1'b0;
   logic          q_empty = 1'b1;
   logic [DW-1:0] q_top = '0;
   logic          r_valid;
   logic          r_ready = 1'b0;
   logic [DW-1:0] r_data;
   logic          r_err;
`ifdef PQ_ISSUER_STATS_EN
   logic [31:0]   st_push, st_pop, st_err;
`endif

   pq_cmd_issuer #(.DATA_WIDTH(DW), .QUEUE_SIZE(QS), .CMD_DEPTH(DEPTH), .SETTLE_CYCLES(SC)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_data(s_data),
      .q_wrt(q_wrt), .q_read(q_read), .q_data(q_data),
      .q_full(q_full), .q_empty(q_empty), .q_top(q_top),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_err(r_err)
`ifdef PQ_ISSUER_STATS_EN
      , .st_push(st_push), .st_pop(st_pop), .st_err(st_err)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          err;
      logic          wrt;
      logic          rd;
      logic [DW-1:0] wd;
      logic [7:0]    lat;
      logic [1:0]    nstr;
      logic          unst;
   } resp_t;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge CLK) cyc++;

   function automatic int qmax(input int q[$]);
      int m = 0;
      foreach (q[i]) if (q[i] > m) m = q[i];
      return m;
   endfunction

   // Behavioural queue standing in for the register tree.
   int mq[$];
   always @(posedge CLK) begin
      if (q_read && mq.size() > 0) begin
         int idx[$];
         int m;
         m = qmax(mq);
         idx = mq.find_first_index(x) with (x == m);
         mq.delete(idx[0]);
      end
      if (q_wrt && mq.size() < QS) mq.push_back(int'(q_data));
      q_empty <= (mq.size() == 0);
      q_full  <= (mq.size() >= QS);
      q_top   <= DW'(qmax(mq));
   end

   // Per-command observation: strobes seen, response fields, latency, stability.
   resp_t cur = '0;
   int    scyc = 0, rcyc = 0, n_strobes = 0;
   logic  rv_prev = 1'b0;
   logic [DW-1:0] prev_d = '0;
   logic  prev_e = 1'b0;
   resp_t resp_log[$];
   int    scyc_log[$];

   always @(negedge CLK) begin
      if (!RSTn) begin
         cur = '0;
         rv_prev = 1'b0;
      end else begin
         if (q_wrt || q_read) begin
            cur.nstr = cur.nstr + 2'd1;
            cur.wrt |= q_wrt;
            cur.rd  |= q_read;
            if (q_wrt) cur.wd = q_data;
            scyc = cyc;
            n_strobes++;
         end
         if (r_valid && rv_prev && (r_data !== prev_d || r_err !== prev_e)) cur.unst = 1'b1;
         if (r_valid && !rv_prev) rcyc = cyc;
         if (r_valid && r_ready) begin
            cur.data = r_data;
            cur.err  = r_err;
            cur.lat  = (cur.nstr != 0) ? 8'(rcyc - scyc) : 8'd0;
            resp_log.push_back(cur);
            scyc_log.push_back(scyc);
            cur = '0;
         end
         rv_prev = r_valid;
         prev_d  = r_data;
         prev_e  = r_err;
      end
   end

   // Command-level reference: queue contents as a plain list, max-first removal.
   int    ref_keys[$];
   resp_t exp_q[$];

   function automatic resp_t ref_cmd(input logic [1:0] op, input logic [DW-1:0] d);
      resp_t e = '0;
      int n = ref_keys.size();
      int m = qmax(ref_keys);
      int idx[$];
      case (op)
         PUSH: if (n < QS && d != 0) begin
                  e.wrt = 1'b1; e.wd = d; ref_keys.push_back(int'(d));
               end else e.err = 1'b1;
         POP:  if (n > 0) begin
                  e.rd = 1'b1; e.data = DW'(m);
                  idx = ref_keys.find_first_index(x) with (x == m);
                  ref_keys.delete(idx[0]);
               end else e.err = 1'b1;
         REPL: if (d == 0) e.err = 1'b1;
               else if (n == 0) begin
                  e.wrt = 1'b1; e.wd = d; e.err = 1'b1; ref_keys.push_back(int'(d));
               end else begin
                  e.wrt = 1'b1; e.rd = 1'b1; e.wd = d; e.data = DW'(m);
                  idx = ref_keys.find_first_index(x) with (x == m);
                  ref_keys.delete(idx[0]);
                  ref_keys.push_back(int'(d));
               end
         default: ;
      endcase
      if (e.wrt || e.rd) begin
         e.lat = 8'd1;
         e.nstr = 2'd1;
      end
      return e;
   endfunction

   task automatic send(input logic [1:0] op, input logic [DW-1:0] d, output bit ok);
      ok = 1'b0;
      s_valid = 1'b1; s_op = op; s_data = d;
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         if (s_ready) begin ok = 1'b1; break; end
         @(posedge CLK); #1;
      end
      if (ok) begin @(posedge CLK); #1; end
      s_valid = 1'b0; s_op = NOP; s_data = '0;
      if (ok && op != NOP) exp_q.push_back(ref_cmd(op, d));
   endtask

   task automatic wait_resps(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         if (resp_log.size() >= n) begin ok = 1'b1; break; end
      end
      @(posedge CLK); #1;
   endtask

   task automatic clear_logs();
      resp_log.delete(); scyc_log.delete(); exp_q.delete();
   endtask

   task automatic test_reset();
      RSTn = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      n_checks++;
      if ({s_ready, r_valid, q_wrt, q_read, r_err} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 10000", {s_ready, r_valid, q_wrt, q_read, r_err});
      end
      n_checks++;
      if (r_data !== '0 || q_data !== '0) begin
         n_fail++; $display("FAIL reset_data: got r_data=%0d q_data=%0d expected 0 0", r_data, q_data);
      end
      RSTn = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      n_checks++;
      if ({s_ready, r_valid} !== 2'b10) begin
         n_fail++; $display("FAIL reset_release: got %b expected 10", {s_ready, r_valid});
      end
   endtask

   task automatic test_push_pop();
      bit ok;
      logic [DW-1:0] keys [3] = '{16'd5, 16'd9, 16'd3};
      clear_logs();
      r_ready = 1'b1;
      foreach (keys[k]) send(PUSH, keys[k], ok);
      wait_resps(3, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL push_timeout: got %0d responses expected 3", resp_log.size()); end
      for (int i = 1; i < scyc_log.size(); i++) begin
         n_checks++;
         if (scyc_log[i] - scyc_log[i-1] !== 2 + SC) begin
            n_fail++; $display("FAIL push_spacing[%0d]: got %0d cycles expected %0d", i, scyc_log[i] - scyc_log[i-1], 2 + SC);
         end
      end
      repeat (3) send(POP, '0, ok);
      wait_resps(6, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL pop_timeout: got %0d responses expected 6", resp_log.size()); end
      for (int i = 0; resp_log.size() > 0 && exp_q.size() > 0; i++) begin
         resp_t o, e;
         o = resp_log.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL push_pop[%0d]: got %p expected %p", i, o, e); end
      end
      repeat (2) @(posedge CLK);
      #1;
      n_checks++;
      if (q_empty !== 1'b1) begin n_fail++; $display("FAIL push_pop_empty: got %b expected 1", q_empty); end
   endtask

   task automatic test_pop_empty();
      bit ok;
      clear_logs();
      send(POP, 16'd77, ok);
      wait_resps(1, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL pop_empty_timeout: got 0 responses expected 1"); end
      while (resp_log.size() > 0 && exp_q.size() > 0) begin
         resp_t o, e;
         o = resp_log.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL pop_empty: got %p expected %p", o, e); end
      end
   endtask

   task automatic test_full();
      bit ok;
      int n;
      clear_logs();
      send(PUSH, 16'd9, ok);
      repeat (QS - 1) send(PUSH, DW'($urandom_range(1, 8)), ok);
      wait_resps(QS, ok);
      repeat (2) @(posedge CLK);
      #1;
      n_checks++;
      if (q_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b expected 1", q_full); end
      send(PUSH, 16'd7, ok);
      send(REPL, 16'd2, ok);
      n = ref_keys.size();
      repeat (n) send(POP, '0, ok);
      wait_resps(QS + 2 + n, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL full_timeout: got %0d responses expected %0d", resp_log.size(), QS + 2 + n); end
      for (int i = 0; resp_log.size() > 0 && exp_q.size() > 0; i++) begin
         resp_t o, e;
         o = resp_log.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL full[%0d]: got %p expected %p", i, o, e); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [1:0] ops [3] = '{PUSH, POP, REPL};
      logic [1:0] op6;
      logic [DW-1:0] d6;
      clear_logs();
      r_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send((i < 2) ? PUSH : ops[$urandom_range(0, 2)], DW'($urandom_range(1, 50)), ok);
         n_checks++;
         if (!ok) begin n_fail++; $display("FAIL bp_accept[%0d]: got not accepted expected accepted", i); end
      end
      op6 = ops[$urandom_range(0, 2)];
      d6 = DW'($urandom_range(1, 50));
      s_valid = 1'b1; s_op = op6; s_data = d6;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      n_checks++;
      if ({s_ready, r_valid} !== 2'b01) begin
         n_fail++; $display("FAIL bp_stall: got s_ready,r_valid=%b expected 01", {s_ready, r_valid});
      end
      @(posedge CLK); #1;
      r_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         if (s_ready) begin ok = 1'b1; break; end
      end
      @(posedge CLK); #1;
      s_valid = 1'b0; s_op = NOP; s_data = '0;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL bp_release: got stuck expected sixth command accepted"); end
      else exp_q.push_back(ref_cmd(op6, d6));
      wait_resps(6, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL bp_timeout: got %0d responses expected 6", resp_log.size()); end
      for (int i = 0; resp_log.size() > 0 && exp_q.size() > 0; i++) begin
         resp_t o, e;
         o = resp_log.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL bp[%0d]: got %p expected %p", i, o, e); end
      end
   endtask

   task automatic test_random();
      bit ok, done;
      int n_exp;
      clear_logs();
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               send(2'($urandom_range(0, 3)), DW'($urandom_range(0, 12)), ok);
               n_checks++;
               if (!ok) begin n_fail++; $display("FAIL rand_accept[%0d]: got not accepted expected accepted", i); end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge CLK); #1;
               r_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      r_ready = 1'b1;
      while (ref_keys.size() > 0) send(POP, '0, ok);
      n_exp = exp_q.size();
      wait_resps(n_exp, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rand_timeout: got %0d responses expected %0d", resp_log.size(), n_exp); end
      for (int i = 0; resp_log.size() > 0 && exp_q.size() > 0; i++) begin
         resp_t o, e;
         o = resp_log.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL rand[%0d]: got %p expected %p", i, o, e); end
      end
   endtask

   task automatic test_reset_settle();
      bit ok;
      int base, snap[$], n;
      clear_logs();
      r_ready = 1'b0;
      base = n_strobes;
      send(PUSH, 16'd11, ok);
      snap = ref_keys;
      send(PUSH, 16'd12, ok);
      send(PUSH, 16'd13, ok);
      for (int i = 0; i < 100 && n_strobes == base; i++) @(posedge CLK);
      n_checks++;
      if (n_strobes == base) begin n_fail++; $display("FAIL rs_strobe: got no strobe expected one"); end
      repeat (2) @(posedge CLK);
      #3 RSTn = 1'b0;
      #1;
      n_checks++;
      if ({r_valid, s_ready, q_wrt, q_read} !== 4'b0100) begin
         n_fail++; $display("FAIL rs_reset: got r_valid,s_ready,q_wrt,q_read=%b expected 0100", {r_valid, s_ready, q_wrt, q_read});
      end
      @(posedge CLK); #1;
      RSTn = 1'b1;
      ref_keys = snap;
      clear_logs();
      r_ready = 1'b1;
      send(PUSH, 16'd4, ok);
      wait_resps(1, ok);
      repeat (30) @(posedge CLK);
      #1;
      n_checks++;
      if (resp_log.size() !== 1) begin n_fail++; $display("FAIL rs_count: got %0d responses expected 1", resp_log.size()); end
      while (resp_log.size() > 0 && exp_q.size() > 0) begin
         resp_t o, e;
         o = resp_log.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL rs_push4: got %p expected %p", o, e); end
      end
      n = ref_keys.size();
      repeat (n) send(POP, '0, ok);
      wait_resps(n, ok);
      for (int i = 0; resp_log.size() > 0 && exp_q.size() > 0; i++) begin
         resp_t o, e;
         o = resp_log.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL rs_drain[%0d]: got %p expected %p", i, o, e); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_push_pop();
      test_pop_empty();
      test_full();
      test_back_to_back();
      test_random();
      test_reset_settle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
